// File: rtl/trace_pkg.sv
// Shared types for the commit-trace monitor: FSM states, halt-cause encoding and trace entry layout.
// Entry fields are sized by TRACE_XLEN, which the top-level XLEN parameter is expected to match.
package trace_pkg;

   localparam int TRACE_XLEN = 32;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'd0,
      CAUSE_PC    = 2'd1,
      CAUSE_LIMIT = 2'd2,
      CAUSE_EXT   = 2'd3
   } cause_t;

   typedef struct packed {
      logic [TRACE_XLEN-1:0] pc;
      logic [31:0]           inst;
      logic [4:0]            rd;
      logic [TRACE_XLEN-1:0] wdata;
   } entry_t;

   // Instructions that do not write a register are recorded with rd = 0.
   function automatic entry_t make_entry(
      input logic [TRACE_XLEN-1:0] pc,
      input logic [31:0]           inst,
      input logic [4:0]            rd,
      input logic                  regwrite,
      input logic [TRACE_XLEN-1:0] wdata
   );
      entry_t e;
      e.pc    = pc;
      e.inst  = inst;
      e.rd    = regwrite ? rd : 5'd0;
      e.wdata = wdata;
      return e;
   endfunction

endpackage

// File: rtl/commit_trace_monitor_ram.sv
// Trace storage: DEPTH entries, one write port and one registered read port (1-cycle read latency).
module trace_ram
   import trace_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  entry_t        wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output entry_t        rdata
);

   entry_t mem [DEPTH];

   // NOTE: the array and read register carry no reset; the top masks stale data with its own reset flops.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/commit_trace_monitor.sv
// Commit-trace and halt monitor: records MEM/WB retires into a first-N or last-N buffer and halts on PC match,
// cycle limit or external stop. Define TRACE_REGMIRROR_EN to add a shadow register file (reg_sel / reg_data).
module commit_trace_monitor
   import trace_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter int              DEPTH      = 32,
   parameter logic [XLEN-1:0] HALT_PC    = 32'h0000_0400,
   parameter int              MAX_CYCLES = 1000,
   parameter int              CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     clear,
   input  logic                     mode,
   input  logic [XLEN-1:0]          fetch_pc,
   input  logic                     wb_valid,
   input  logic [XLEN-1:0]          wb_pc,
   input  logic [31:0]              wb_inst,
   input  logic [4:0]               wb_rd,
   input  logic                     wb_regwrite,
   input  logic [XLEN-1:0]          wb_wdata,
   input  logic                     rd_req,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic                     rd_valid,
   output logic [XLEN-1:0]          rd_pc,
   output logic [31:0]              rd_inst,
   output logic [4:0]               rd_rd,
   output logic [XLEN-1:0]          rd_wdata,
   output logic [1:0]               state,
   output logic [1:0]               halt_cause,
   output logic [CNT_W-1:0]         cycle_count,
   output logic [CNT_W-1:0]         retire_count,
   output logic [$clog2(DEPTH):0]   trace_count,
   output logic                     overflow
`ifdef TRACE_REGMIRROR_EN
  ,input  logic [4:0]               reg_sel,
   output logic [XLEN-1:0]          reg_data
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0]    FULL_C  = CW'(DEPTH);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(MAX_CYCLES - 1);

   state_t           state_q, next_state;
   cause_t           cause_q, next_cause;
   logic             mode_q;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count_q;
   logic [CNT_W-1:0] cyc_q, ret_q;
   logic             ovf_q;

   logic             run_active, retire, full, wr_en;
   logic             pc_hit, lim_hit;
   logic [AW-1:0]    oldest, rd_phys;
   logic             rd_in_range, rd_valid_q, rd_hit_q;
   entry_t           wr_entry, rd_entry;

   assign run_active = (state_q == S_RUN) && !start;
   assign retire     = run_active && wb_valid;
   assign full       = (count_q == FULL_C);
   assign wr_en      = retire && (mode_q || !full);
   assign pc_hit     = (fetch_pc == HALT_PC);
   assign lim_hit    = (MAX_CYCLES != 0) && (cyc_q == LIMIT_C);
   assign wr_entry   = make_entry(wb_pc, wb_inst, wb_rd, wb_regwrite, wb_wdata);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      next_state = state_q;
      next_cause = cause_q;
      if (start) begin
         next_state = S_RUN;
         next_cause = CAUSE_NONE;
      end else begin
         case (state_q)
            S_RUN: begin
               if (pc_hit || lim_hit || stop) next_state = S_HALTED;
               if (pc_hit)       next_cause = CAUSE_PC;
               else if (lim_hit) next_cause = CAUSE_LIMIT;
               else if (stop)    next_cause = CAUSE_EXT;
            end
            S_HALTED: if (clear) next_state = S_IDLE;
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= next_state;
         cause_q <= next_cause;
      end
   end

   // Counters, capture pointer and overflow; the halting cycle still counts and captures.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= 1'b0;
         wr_ptr  <= '0;
         count_q <= '0;
         cyc_q   <= '0;
         ret_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (start) begin
         mode_q  <= mode;
         wr_ptr  <= '0;
         count_q <= '0;
         cyc_q   <= '0;
         ret_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (state_q == S_RUN) begin
         if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;
         if (wb_valid) begin
            if (ret_q != '1) ret_q <= ret_q + 1'b1;
            if (full) ovf_q <= 1'b1;
            else      count_q <= count_q + 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         end
      end
   end

   // Logical index 0 is the oldest entry: the write pointer once a circular buffer has wrapped.
   assign oldest      = (mode_q && full) ? wr_ptr : '0;
   assign rd_phys     = oldest + rd_idx;
   assign rd_in_range = ({1'b0, rd_idx} < count_q);

   trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .re    (rd_req),
      .raddr (rd_phys),
      .rdata (rd_entry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_hit_q   <= 1'b0;
      end else begin
         rd_valid_q <= rd_req;
         rd_hit_q   <= rd_req && rd_in_range;
      end
   end

   assign rd_valid     = rd_valid_q;
   assign rd_pc        = rd_hit_q ? rd_entry.pc    : '0;
   assign rd_inst      = rd_hit_q ? rd_entry.inst  : '0;
   assign rd_rd        = rd_hit_q ? rd_entry.rd    : '0;
   assign rd_wdata     = rd_hit_q ? rd_entry.wdata : '0;
   assign state        = state_q;
   assign halt_cause   = cause_q;
   assign cycle_count  = cyc_q;
   assign retire_count = ret_q;
   assign trace_count  = count_q;
   assign overflow     = ovf_q;

`ifdef TRACE_REGMIRROR_EN
   logic [XLEN-1:0] mirror_q [32];

   always_ff @(posedge clk) begin
      if (rst || start) begin
         for (int i = 0; i < 32; i++) mirror_q[i] <= '0;
      end else if (retire && wb_regwrite && (wb_rd != 5'd0)) begin
         mirror_q[wb_rd] <= wb_wdata;
      end
   end

   assign reg_data = (reg_sel == 5'd0) ? '0 : mirror_q[reg_sel];
`else
   // Register mirror not built: no shadow storage, no extra ports.
`endif

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Randomised self-checking bench for commit_trace_monitor (DEPTH=4, MAX_CYCLES=10) against a queue-based model.
module tb_commit_trace_monitor;

   localparam int          XLEN       = 32;
   localparam int          DEPTH      = 4;
   localparam int          MAX_CYCLES = 10;
   localparam int          CNT_W      = 16;
   localparam logic [31:0] HALT_PC    = 32'h0000_0400;

   logic        clk = 1'b0;
   logic        rst, start, stop, clear, mode;
   logic [31:0] fetch_pc, wb_pc, wb_inst, wb_wdata;
   logic        wb_valid, wb_regwrite, rd_req;
   logic [4:0]  wb_rd;
   logic [1:0]  rd_idx;
   logic        rd_valid, overflow;
   logic [31:0] rd_pc, rd_inst, rd_wdata;
   logic [4:0]  rd_rd;
   logic [1:0]  state, halt_cause;
   logic [15:0] cycle_count, retire_count;
   logic [2:0]  trace_count;
`ifdef TRACE_REGMIRROR_EN
   logic [4:0]  reg_sel;
   logic [31:0] reg_data;
`endif

   commit_trace_monitor #(
      .XLEN(XLEN), .DEPTH(DEPTH), .HALT_PC(HALT_PC), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .mode(mode),
      .fetch_pc(fetch_pc), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
      .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_wdata(wb_wdata),
      .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_pc(rd_pc),
      .rd_inst(rd_inst), .rd_rd(rd_rd), .rd_wdata(rd_wdata), .state(state),
      .halt_cause(halt_cause), .cycle_count(cycle_count), .retire_count(retire_count),
      .trace_count(trace_count), .overflow(overflow)
`ifdef TRACE_REGMIRROR_EN
     ,.reg_sel(reg_sel), .reg_data(reg_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } ent_t;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: logical trace kept oldest-first in a queue.
   ent_t        q[$];
   int          m_state = 0, m_cause = 0, m_cycle = 0, m_retire = 0, cause_n;
   bit          m_mode = 0, m_ovf = 0;
   bit          e_rv = 0;
   ent_t        e_rd = '{default: '0};
   ent_t        zero_ent = '{default: '0};
   ent_t        ne;
   logic [31:0] m_mirror [32];
   bit          chk_en = 0;

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_state = 0; m_cause = 0; m_cycle = 0; m_retire = 0; m_mode = 0; m_ovf = 0;
         e_rv = 0; e_rd = zero_ent;
         for (int i = 0; i < 32; i++) m_mirror[i] = '0;
      end else begin
         e_rv = rd_req;
         e_rd = zero_ent;
         if (rd_req && (int'(rd_idx) < q.size())) e_rd = q[rd_idx];
         if (start) begin
            q.delete();
            m_state = 1; m_cause = 0; m_cycle = 0; m_retire = 0; m_ovf = 0; m_mode = mode;
            for (int i = 0; i < 32; i++) m_mirror[i] = '0;
         end else if (m_state == 1) begin
            cause_n = 0;
            if (fetch_pc == HALT_PC) cause_n = 1;
            else if (MAX_CYCLES != 0 && m_cycle == MAX_CYCLES - 1) cause_n = 2;
            else if (stop) cause_n = 3;
            if (m_cycle < 65535) m_cycle++;
            if (wb_valid) begin
               if (m_retire < 65535) m_retire++;
               ne.pc = wb_pc; ne.inst = wb_inst; ne.wdata = wb_wdata;
               ne.rd = wb_regwrite ? wb_rd : 5'd0;
               if (q.size() < DEPTH) q.push_back(ne);
               else begin
                  m_ovf = 1;
                  if (m_mode) begin
                     void'(q.pop_front());
                     q.push_back(ne);
                  end
               end
               if (wb_regwrite && wb_rd != 0) m_mirror[wb_rd] = wb_wdata;
            end
            if (cause_n != 0) begin
               m_state = 2;
               m_cause = cause_n;
            end
         end else if (m_state == 2 && clear) begin
            m_state = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("state", state, m_state);
         check("halt_cause", halt_cause, m_cause);
         check("cycle_count", cycle_count, m_cycle);
         check("retire_count", retire_count, m_retire);
         check("trace_count", trace_count, q.size());
         check("overflow", overflow, m_ovf);
         check("rd_valid", rd_valid, e_rv);
         if (e_rv) begin
            check("rd_pc", rd_pc, e_rd.pc);
            check("rd_inst", rd_inst, e_rd.inst);
            check("rd_rd", rd_rd, e_rd.rd);
            check("rd_wdata", rd_wdata, e_rd.wdata);
         end
`ifdef TRACE_REGMIRROR_EN
         check("reg_data", reg_data, (reg_sel == 0) ? 32'd0 : m_mirror[reg_sel]);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic quiet();
      rst = 0; start = 0; stop = 0; clear = 0; mode = 0;
      fetch_pc = 32'h0; wb_valid = 0; wb_pc = 0; wb_inst = 0; wb_rd = 0;
      wb_regwrite = 0; wb_wdata = 0; rd_req = 0; rd_idx = 0;
`ifdef TRACE_REGMIRROR_EN
      reg_sel = 0;
`endif
   endtask

   task automatic retire_at(input logic [31:0] pc);
      wb_valid = 1; wb_pc = pc; wb_inst = $urandom; wb_rd = 5'($urandom_range(1, 31));
      wb_regwrite = 1; wb_wdata = $urandom;
      tick();
      wb_valid = 0;
   endtask

   task automatic fill_six(input logic m);
      start = 1; mode = m; tick(); start = 0;
      for (int i = 0; i < 6; i++) retire_at(32'(i * 4));
      check("fill_tcount", trace_count, 4);
      check("fill_ovf", overflow, 1);
      check("fill_retire", retire_count, 6);
      stop = 1; tick(); stop = 0;
      check("stop_cause", halt_cause, 3);
      check("stop_cycles", cycle_count, 7);
   endtask

   task automatic read_check(input int idx, input logic [31:0] exp_pc);
      rd_req = 1; rd_idx = 2'(idx); tick(); rd_req = 0;
      check("rd_literal_valid", rd_valid, 1);
      check("rd_literal_pc", rd_pc, exp_pc);
   endtask

   initial begin
      quiet();
      rst = 1;
      tick();
      chk_en = 1;
      rst = 0;
      check("reset_state", state, 0);
      check("reset_cycles", cycle_count, 0);
      check("reset_rd_valid", rd_valid, 0);
      check("reset_rd_pc", rd_pc, 0);

      // First-N capture keeps the first four PCs.
      fill_six(1'b0);
      for (int i = 0; i < 4; i++) read_check(i, 32'(i * 4));

      // Last-N capture keeps the newest four PCs.
      fill_six(1'b1);
      for (int i = 0; i < 4; i++) read_check(i, 32'(8 + i * 4));

      // PC match at RUN cycle 7 with a simultaneous retire.
      start = 1; mode = 0; tick(); start = 0;
      for (int c = 0; c < 7; c++) begin fetch_pc = 32'(c * 4); tick(); end
      fetch_pc = HALT_PC;
      retire_at(32'h1c);
      fetch_pc = 0;
      check("pc_state", state, 2);
      check("pc_cause", halt_cause, 1);
      check("pc_cycles", cycle_count, 8);
      check("pc_retire", retire_count, 1);
      retire_at(32'h20);
      retire_at(32'h24);
      check("halted_retire", retire_count, 1);
      check("halted_tcount", trace_count, 1);

      // Cycle limit with a coincident stop: the limit wins.
      clear = 1; tick(); clear = 0;
      check("clear_idle", state, 0);
      start = 1; tick(); start = 0;
      for (int c = 0; c < 9; c++) tick();
      stop = 1; tick(); stop = 0;
      check("lim_state", state, 2);
      check("lim_cause", halt_cause, 2);
      check("lim_cycles", cycle_count, 10);

      // Reset mid-RUN, then a read of an empty buffer.
      start = 1; tick(); start = 0;
      for (int i = 0; i < 3; i++) retire_at(32'h100 + 32'(i * 4));
      rst = 1; tick(); rst = 0;
      check("rst_state", state, 0);
      check("rst_retire", retire_count, 0);
      check("rst_tcount", trace_count, 0);
      check("rst_rd_valid", rd_valid, 0);
      start = 1; tick(); start = 0;
      rd_req = 1; rd_idx = 0; tick(); rd_req = 0;
      check("empty_rd_valid", rd_valid, 1);
      check("empty_rd_pc", rd_pc, 0);

`ifdef TRACE_REGMIRROR_EN
      wb_valid = 1; wb_regwrite = 1; wb_rd = 5; wb_wdata = 32'hDEAD_BEEF; tick();
      wb_rd = 0; wb_wdata = 32'h1; tick();
      wb_valid = 0;
      reg_sel = 5; #1;
      check("mirror_x5", reg_data, 32'hDEAD_BEEF);
      reg_sel = 0; #1;
      check("mirror_x0", reg_data, 0);
`endif

      // Randomised traffic.
      for (int n = 0; n < 3000; n++) begin
         rst         = ($urandom_range(99) == 0);
         start       = ($urandom_range(14) == 0);
         stop        = ($urandom_range(19) == 0);
         clear       = ($urandom_range(3) == 0);
         mode        = 1'($urandom);
         fetch_pc    = ($urandom_range(24) == 0) ? HALT_PC : ($urandom & 32'hFFFF_FFFC);
         wb_valid    = 1'($urandom);
         wb_pc       = $urandom & 32'hFFFF_FFFC;
         wb_inst     = $urandom;
         wb_rd       = 5'($urandom);
         wb_regwrite = 1'($urandom);
         wb_wdata    = $urandom;
         rd_req      = 1'($urandom);
         rd_idx      = 2'($urandom);
`ifdef TRACE_REGMIRROR_EN
         reg_sel     = 5'($urandom);
`endif
         tick();
      end

      quiet();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/commit_trace_monitor.md
Name: commit_trace_monitor

Overview:
- Synthesizable, parametrised commit-trace and halt monitor for the pipelined RISC-V core.
- Snoops the MEM/WB writeback stream and the fetch PC.
- Records retired instructions into an on-chip trace buffer, in either first-N or last-N mode.
- Halts capture on a halt-PC match, a cycle limit, or an external stop; exposes buffer readout and counters for on-board debug.

Parameters:
- XLEN, 32, data/PC width
- DEPTH, 32, trace entries; power of two, >= 4
- HALT_PC, 32'h0000_0400, fetch PC that triggers halt
- MAX_CYCLES, 1000, RUN-cycle limit; 0 disables the limit
- CNT_W, 16, width of the cycle and retire counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: arm monitor and clear buffer and counters
- stop  in  1  pulse: external halt request
- clear  in  1  pulse: HALTED -> IDLE
- mode  in  1  sampled on start; 0 = first-N capture, 1 = circular last-N
- fetch_pc  in  XLEN  current IF PC
- wb_valid  in  1  MEM/WB entry valid (retire)
- wb_pc  in  XLEN  retiring PC
- wb_inst  in  32  retiring instruction
- wb_rd  in  5  destination register
- wb_regwrite  in  1  register write enable
- wb_wdata  in  XLEN  writeback data
- rd_req  in  1  readout request
- rd_idx  in  $clog2(DEPTH)  logical index; 0 = oldest entry
- rd_valid  out  1  readout data valid
- rd_pc  out  XLEN  entry PC
- rd_inst  out  32  entry instruction
- rd_rd  out  5  entry rd; wb_regwrite=0 stored as 0
- rd_wdata  out  XLEN  entry writeback data
- state  out  2  IDLE=0, RUN=1, HALTED=2
- halt_cause  out  2  0 none, 1 pc match, 2 cycle limit, 3 external
- cycle_count  out  CNT_W  RUN cycles elapsed
- retire_count  out  CNT_W  retires seen in RUN
- trace_count  out  $clog2(DEPTH)+1  valid entries, saturates at DEPTH
- overflow  out  1  retires dropped (mode 0) or overwritten (mode 1)

Behaviour:
- Reset: state=IDLE. All counters, halt_cause, overflow, rd_valid and write pointer are 0. rd_* data outputs are 0.
- IDLE -> RUN on start. Start clears the buffer, counters, overflow and halt_cause, and latches mode.
- start while in RUN or HALTED: same restart behaviour.
- RUN, each cycle:
  - cycle_count += 1, saturating at all-ones.
  - If wb_valid: retire_count += 1 (saturating); capture the entry.
- Capture, mode 0:
  - Write while trace_count < DEPTH.
  - Once full, drop the entry and set overflow.
- Capture, mode 1:
  - Always write at wr_ptr; the pointer wraps modulo DEPTH.
  - When full, the oldest entry is overwritten and overflow is set.
  - Oldest entry = wr_ptr when full, otherwise 0.
- Halt evaluation in RUN: pc match (fetch_pc == HALT_PC), limit (MAX_CYCLES != 0 and cycle_count == MAX_CYCLES-1), or stop.
  - On halt: next state = HALTED; halt_cause = highest-priority cause (pc > limit > ext).
  - A retire in the halting cycle is captured, and that cycle is counted.
- HALTED: counters and buffer are frozen; wb_valid is ignored. clear -> IDLE (buffer contents retained). start has priority over clear.
- Readout (any state): rd_req samples rd_idx. One cycle later rd_valid=1 and rd_* hold the entry at physical index (oldest + rd_idx) mod DEPTH.
  - rd_idx >= trace_count returns zeros with rd_valid=1.
  - A same-cycle capture is not visible to a read issued in that cycle.
- Mid-operation rst returns everything to reset values within one edge.

Optional Feature:
- Macro TRACE_REGMIRROR_EN.
- Defined:
  - Adds ports reg_sel in 5 and reg_data out XLEN.
  - Keeps a 32-entry shadow register file, written in RUN on wb_valid & wb_regwrite & wb_rd != 0.
  - reg_data is a combinational read; reg_sel=0 returns 0.
  - Mirror is cleared on rst and on start.
- Undefined: these ports and the storage are absent.

Decomposition:
- Package trace_pkg: state enum (IDLE/RUN/HALTED), halt_cause encoding, trace entry struct {pc, inst, rd, wdata}.
- One sub-module, trace_ram: DEPTH x entry, single write port, registered read port. It holds the 1-cycle read latency.

Test Plan:
- Mode 0, DEPTH=4: start, then 6 retires with PCs 0,4,...,20 -> trace_count=4, overflow=1, rd_idx 0..3 return PCs 0,4,8,12.
- Mode 1, DEPTH=4: same 6 retires -> rd_idx 0..3 return PCs 8,12,16,20, overflow=1.
- fetch_pc=0x400 at RUN cycle 7 with a simultaneous retire -> state=HALTED next cycle, halt_cause=1, cycle_count=8, retire included. Retires afterwards leave retire_count unchanged.
- MAX_CYCLES=10, no PC match -> halt with cause 2 and cycle_count=10. stop asserted in the same cycle as the limit -> cause 2, not 3.
- rst pulse mid-RUN after 3 retires -> state=IDLE, all counters 0, rd_valid=0. A read at rd_idx=0 after start returns zeros.
- With TRACE_REGMIRROR_EN: writes x5=0xDEADBEEF and x0=0x1 -> reg_sel=5 gives 0xDEADBEEF, reg_sel=0 gives 0.
